control_sequencer: RTL and testbench

Multi-cycle fetch/decode/execute controller that sits directly upstream of the 4-register datapath and drives its control word (AA, BA, DA, FS, CI, LE, MD, MB) each instruction. It fetches 16-bit instructions over a valid-qualified instruction port and sequences data-memory loads and stores through a ready handshake. It captures the datapath's N/Z flags for conditional branches.

---
 rtl/control_sequencer.sv | 166 ++++++++++++++++
 tb/tb_control_sequencer.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Multi-cycle fetch/decode/execute controller driving the 4-register datapath control word.
// Fetches 16-bit instructions, sequences data-memory loads/stores and conditional branches.
module control_sequencer #(
  parameter int unsigned PC_W     = 8,
  parameter logic [3:0]  FS_PASSB = 4'b1100,
  parameter logic [3:0]  FS_ADD   = 4'b0010
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            run,
  input  logic [15:0]     ir_data,
  input  logic            ir_valid,
  input  logic            dmem_ready,
  input  logic            N,
  input  logic            Z,
  output logic [PC_W-1:0] pc,
  output logic            ir_req,
  output logic [1:0]      AA,
  output logic [1:0]      BA,
  output logic [1:0]      DA,
  output logic [3:0]      FS,
  output logic [7:0]      CI,
  output logic            LE,
  output logic            MD,
  output logic            MB,
  output logic            dmem_rd,
  output logic            dmem_wr,
  output logic            halted
);

  localparam logic [3:0] OpNop  = 4'h0;
  localparam logic [3:0] OpAlu  = 4'h1;
  localparam logic [3:0] OpLdi  = 4'h2;
  localparam logic [3:0] OpAddi = 4'h3;
  localparam logic [3:0] OpLd   = 4'h4;
  localparam logic [3:0] OpSt   = 4'h5;
  localparam logic [3:0] OpBz   = 4'h8;
  localparam logic [3:0] OpBn   = 4'h9;
  localparam logic [3:0] OpJmp  = 4'hA;
  localparam logic [3:0] OpHalt = 4'hF;

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StMem, StHalt} state_e;

  state_e          state_q;
  logic [PC_W-1:0] pc_q;
  logic [15:0]     ir_q;
  logic            n_q;
  logic            z_q;

  logic [3:0] op;
  logic [1:0] da;
  logic [1:0] aa;
  logic [1:0] ba;
  logic [3:0] fs;
  logic [7:0] imm;

  assign op  = ir_q[15:12];
  assign da  = ir_q[11:10];
  assign aa  = ir_q[9:8];
  assign ba  = ir_q[7:6];
  assign fs  = ir_q[3:0];
  assign imm = ir_q[7:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      pc_q    <= '0;
      ir_q    <= '0;
      n_q     <= 1'b0;
      z_q     <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (run) state_q <= StFetch;
        end
        StFetch: begin
          if (ir_valid) begin
            ir_q    <= ir_data;
            pc_q    <= pc_q + PC_W'(1);
            state_q <= StExec;
          end
        end
        StExec: begin
          case (op)
            OpAlu, OpAddi: begin
              n_q <= N;
              z_q <= Z;
            end
            // pc already points past the branch; offset is a signed byte
            OpBz:    if (z_q) pc_q <= pc_q + PC_W'($signed(imm));
            OpBn:    if (n_q) pc_q <= pc_q + PC_W'($signed(imm));
            OpJmp:   pc_q <= PC_W'(imm);
            default: ;
          endcase
          if (op == OpLd || op == OpSt) state_q <= StMem;
          else if (op == OpHalt)        state_q <= StHalt;
          else                          state_q <= run ? StFetch : StIdle;
        end
        StMem: begin
          if (dmem_ready) state_q <= run ? StFetch : StIdle;
        end
        StHalt:  state_q <= StHalt;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pc     = pc_q;
  assign ir_req = (state_q == StFetch);
  assign halted = (state_q == StHalt);

  // Control word decodes from registered state; only LD's LE follows dmem_ready.
  always_comb begin
    AA      = 2'd0;
    BA      = 2'd0;
    DA      = 2'd0;
    FS      = 4'd0;
    CI      = 8'd0;
    LE      = 1'b0;
    MD      = 1'b0;
    MB      = 1'b0;
    dmem_rd = 1'b0;
    dmem_wr = 1'b0;
    if (state_q == StExec || state_q == StMem) begin
      case (op)
        OpAlu: begin
          DA = da;
          AA = aa;
          BA = ba;
          FS = fs;
          LE = 1'b1;
        end
        OpLdi: begin
          DA = da;
          CI = imm;
          MB = 1'b1;
          FS = FS_PASSB;
          LE = 1'b1;
        end
        OpAddi: begin
          DA = da;
          AA = aa;
          CI = imm;
          MB = 1'b1;
          FS = FS_ADD;
          LE = 1'b1;
        end
        OpLd: begin
          AA      = aa;
          DA      = da;
          MD      = 1'b1;
          dmem_rd = 1'b1;
          LE      = (state_q == StMem) && dmem_ready;
        end
        OpSt: begin
          AA      = aa;
          BA      = ba;
          dmem_wr = 1'b1;
        end
        OpNop:   ;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: cycle-by-cycle stimulus with hand-computed
// expectations for fetch/exec sequencing, branches, memory handshakes, halt and reset.
module tb_control_sequencer;

  logic        clk;
  logic        rst;
  logic        run;
  logic [15:0] ir_data;
  logic        ir_valid;
  logic        dmem_ready;
  logic        N;
  logic        Z;
  logic [7:0]  pc;
  logic        ir_req;
  logic [1:0]  AA;
  logic [1:0]  BA;
  logic [1:0]  DA;
  logic [3:0]  FS;
  logic [7:0]  CI;
  logic        LE;
  logic        MD;
  logic        MB;
  logic        dmem_rd;
  logic        dmem_wr;
  logic        halted;

  logic [15:0] imem [256];
  int          n_cmp;
  int          n_mis;

  control_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .run        (run),
    .ir_data    (ir_data),
    .ir_valid   (ir_valid),
    .dmem_ready (dmem_ready),
    .N          (N),
    .Z          (Z),
    .pc         (pc),
    .ir_req     (ir_req),
    .AA         (AA),
    .BA         (BA),
    .DA         (DA),
    .FS         (FS),
    .CI         (CI),
    .LE         (LE),
    .MD         (MD),
    .MB         (MB),
    .dmem_rd    (dmem_rd),
    .dmem_wr    (dmem_wr),
    .halted     (halted)
  );

  assign ir_data = imem[pc];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge; caller may then change inputs.
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  // Advance one cycle and let combinational outputs settle.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    for (int i = 0; i < 256; i++) imem[i] = 16'h0000;
    imem[0] = 16'h245A;  // LDI R1,0x5A
    imem[1] = 16'h0000;  // NOP
    imem[2] = 16'h1D85;  // ALU R3=R1 fs5 R2
    imem[3] = 16'h3903;  // ADDI R2=R1+3
    imem[4] = 16'h80FC;  // BZ -4
    imem[5] = 16'h9002;  // BN +2
    imem[8] = 16'h4300;  // LD R0,[R3]
    imem[9] = 16'hA0FF;  // JMP 0xFF

    rst = 1'b1; run = 1'b0; ir_valid = 1'b1; dmem_ready = 1'b0; N = 1'b0; Z = 1'b0;
    #3;
    chk("rst_pc", pc, 0);
    chk("rst_ir_req", ir_req, 0);
    chk("rst_halted", halted, 0);
    chk("rst_le", LE, 0);

    // C0 idle
    nxt(); rst = 1'b0; run = 1'b1; #1;
    chk("c0_idle_ir_req", ir_req, 0);
    chk("c0_pc", pc, 0);
    // C1 fetch 0
    cyc();
    chk("c1_ir_req", ir_req, 1);
    chk("c1_pc", pc, 0);
    chk("c1_le", LE, 0);
    // C2 exec LDI
    cyc();
    chk("c2_ir_req", ir_req, 0);
    chk("c2_pc", pc, 1);
    chk("ldi_da", DA, 1);
    chk("ldi_ci", CI, 16'h5A);
    chk("ldi_mb", MB, 1);
    chk("ldi_fs", FS, 4'b1100);
    chk("ldi_le", LE, 1);
    chk("ldi_md", MD, 0);
    // C3 fetch 1
    cyc();
    chk("c3_ir_req", ir_req, 1);
    chk("c3_le", LE, 0);
    chk("c3_ci", CI, 0);
    chk("c3_pc", pc, 1);
    // C4 exec NOP
    cyc();
    chk("nop_le", LE, 0);
    chk("c4_pc", pc, 2);
    // C5 fetch 2, C6 exec ALU
    cyc();
    nxt(); N = 1'b1; Z = 1'b0; #1;
    chk("alu_da", DA, 3);
    chk("alu_aa", AA, 1);
    chk("alu_ba", BA, 2);
    chk("alu_fs", FS, 5);
    chk("alu_le", LE, 1);
    chk("alu_mb", MB, 0);
    // C7 fetch 3, C8 exec ADDI with N=0 Z=1
    cyc();
    nxt(); N = 1'b0; Z = 1'b1; #1;
    chk("addi_da", DA, 2);
    chk("addi_aa", AA, 1);
    chk("addi_ci", CI, 3);
    chk("addi_mb", MB, 1);
    chk("addi_fs", FS, 4'b0010);
    chk("addi_le", LE, 1);
    // C9 fetch 4; live flags change but captured Z must be used
    nxt(); N = 1'b0; Z = 1'b0; #1;
    chk("c9_pc", pc, 4);
    // C10 exec BZ taken
    cyc();
    chk("bz_pc_incr", pc, 5);
    chk("bz_le", LE, 0);
    // C11 fetch at branch target
    cyc();
    chk("bz_taken_pc", pc, 1);
    chk("c11_ir_req", ir_req, 1);
    // C12 NOP, C13 fetch 2, C14 ALU N=0 Z=0
    cyc();
    cyc();
    nxt(); N = 1'b0; Z = 1'b0; #1;
    chk("alu2_le", LE, 1);
    // C15 fetch 3, C16 ADDI N=1 Z=0
    cyc();
    nxt(); N = 1'b1; Z = 1'b0; #1;
    chk("addi2_le", LE, 1);
    // C17 fetch 4 with live Z=1 (must be ignored), C18 BZ not taken
    nxt(); N = 1'b0; Z = 1'b1; #1;
    cyc();
    // C19 fetch 5
    cyc();
    chk("bz_not_taken_pc", pc, 5);
    // C20 BN taken: 6+2
    cyc();
    // C21 fetch 8
    cyc();
    chk("bn_taken_pc", pc, 8);
    // C22 exec LD; ready here must be ignored
    nxt(); dmem_ready = 1'b1; #1;
    chk("ld_exec_rd", dmem_rd, 1);
    chk("ld_exec_md", MD, 1);
    chk("ld_exec_le", LE, 0);
    chk("ld_aa", AA, 3);
    chk("ld_da", DA, 0);
    // C23 MEM wait
    nxt(); dmem_ready = 1'b0; #1;
    chk("ld_wait_rd", dmem_rd, 1);
    chk("ld_wait_md", MD, 1);
    chk("ld_wait_le", LE, 0);
    // C24 MEM done
    nxt(); dmem_ready = 1'b1; #1;
    chk("ld_done_rd", dmem_rd, 1);
    chk("ld_done_md", MD, 1);
    chk("ld_done_le", LE, 1);
    chk("ld_done_ir_req", ir_req, 0);
    // C25 fetch 9
    nxt(); dmem_ready = 1'b0; #1;
    chk("c25_rd", dmem_rd, 0);
    chk("c25_md", MD, 0);
    chk("c25_pc", pc, 9);
    // C26 JMP, C27 fetch 0xFF, C28 NOP with wrapped pc
    cyc();
    cyc();
    chk("jmp_pc", pc, 16'hFF);
    cyc();
    chk("wrap_pc", pc, 0);

    // Store / halt program
    rst = 1'b1;
    imem[0] = 16'h5240;  // ST [R2],R1
    imem[1] = 16'hF000;  // HALT
    nxt(); rst = 1'b0; run = 1'b1; dmem_ready = 1'b0; N = 1'b0; Z = 1'b0; #1;
    chk("d0_pc", pc, 0);
    // D1 fetch 0, D2 exec ST
    cyc();
    cyc();
    chk("st_wr", dmem_wr, 1);
    chk("st_aa", AA, 2);
    chk("st_ba", BA, 1);
    chk("st_le", LE, 0);
    chk("st_mb", MB, 0);
    // D3 MEM, run dropped, not ready
    nxt(); run = 1'b0; #1;
    chk("st_wait_wr", dmem_wr, 1);
    // D4 MEM ready
    nxt(); dmem_ready = 1'b1; #1;
    chk("st_done_wr", dmem_wr, 1);
    // D5 idle
    nxt(); dmem_ready = 1'b0; #1;
    chk("st_idle_wr", dmem_wr, 0);
    chk("st_idle_ir_req", ir_req, 0);
    chk("st_idle_pc", pc, 1);
    // D6 still idle
    cyc();
    chk("d6_ir_req", ir_req, 0);
    ir_valid = 1'b0;
    run = 1'b1;
    // D7, D8 fetch stalled at pc=1
    cyc();
    chk("d7_ir_req", ir_req, 1);
    cyc();
    chk("d8_pc", pc, 1);
    rst = 1'b1;
    #1;
    chk("async_rst_pc", pc, 0);
    chk("async_rst_ir_req", ir_req, 0);

    imem[0] = 16'hF000;
    nxt(); rst = 1'b0; ir_valid = 1'b1; #1;
    // E1 fetch, E2 exec HALT, E3.. halted
    cyc();
    cyc();
    chk("halt_exec_halted", halted, 0);
    cyc();
    chk("halted", halted, 1);
    chk("halt_ir_req", ir_req, 0);
    chk("halt_le", LE, 0);
    cyc();
    cyc();
    chk("halt_hold", halted, 1);
    chk("halt_hold_ir_req", ir_req, 0);
    rst = 1'b1;
    #1;
    chk("halt_rst", halted, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
